// File: rtl/aibndaux_por_seq_master.sv
// Master-side AUX power-on sequencer: debounces slave detect/dn_por and reports link-ready.
// Optional POR_WAIT timeout and FAULT state are enabled by defining AIBNDAUX_POR_TMO_EN.
module aibndaux_por_seq_master #(
    parameter int unsigned       DBNC_W   = 8,
    parameter logic [DBNC_W-1:0] DBNC_CNT = 8'd200,
    parameter int unsigned       TMO_W    = 16,
    parameter logic [TMO_W-1:0]  TMO_CNT  = 16'd50000
) (
    input  logic       i_aux_clk,
    input  logic       i_aux_rst_n,
    input  logic       i_device_detect,
    input  logic       i_dn_por,
    input  logic       i_crdet_ovrd,
    input  logic       i_retry,
    output logic       o_device_detect,
    output logic       o_link_ready,
    output logic       o_link_drop,
    output logic       o_timeout,
    output logic [2:0] o_state
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_DET_DBNC = 3'd1;
    localparam logic [2:0] ST_POR_WAIT = 3'd2;
    localparam logic [2:0] ST_POR_DBNC = 3'd3;
    localparam logic [2:0] ST_READY    = 3'd4;
    localparam logic [2:0] ST_FAULT    = 3'd5;

    localparam logic [DBNC_W-1:0] DBNC_LAST = DBNC_CNT - 1'b1;

    logic              det_m, det_s;
    logic              por_m, por_s;
    logic              det;
    logic [2:0]        state, state_next;
    logic [DBNC_W-1:0] dcnt;
    logic              link_drop;

`ifdef AIBNDAUX_POR_TMO_EN
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_CNT - 1'b1;
    logic [TMO_W-1:0] tcnt;
`endif

    // por_s resets to 1 so a freshly reset master treats the slave as still in POR.
    always_ff @(posedge i_aux_clk or negedge i_aux_rst_n) begin
        if (!i_aux_rst_n) begin
            det_m <= 1'b0;
            det_s <= 1'b0;
            por_m <= 1'b1;
            por_s <= 1'b1;
        end else begin
            det_m <= i_device_detect;
            det_s <= det_m;
            por_m <= i_dn_por;
            por_s <= por_m;
        end
    end

    assign det = det_s | i_crdet_ovrd;

    // Priority inside each state: detect loss, then POR event, then terminal count.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (det) state_next = ST_DET_DBNC;
            end
            ST_DET_DBNC: begin
                if (!det)                   state_next = ST_IDLE;
                else if (dcnt == DBNC_LAST) state_next = ST_POR_WAIT;
            end
            ST_POR_WAIT: begin
                if (!det)        state_next = ST_IDLE;
                else if (!por_s) state_next = ST_POR_DBNC;
`ifdef AIBNDAUX_POR_TMO_EN
                else if (tcnt == TMO_LAST) state_next = ST_FAULT;
`endif
            end
            ST_POR_DBNC: begin
                if (!det)                   state_next = ST_IDLE;
                else if (por_s)             state_next = ST_POR_WAIT;
                else if (dcnt == DBNC_LAST) state_next = ST_READY;
            end
            ST_READY: begin
                if (!det || por_s) state_next = ST_IDLE;
            end
            ST_FAULT: begin
`ifdef AIBNDAUX_POR_TMO_EN
                if (!det)         state_next = ST_IDLE;
                else if (i_retry) state_next = ST_POR_WAIT;
`else
                state_next = ST_IDLE;
`endif
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_aux_clk or negedge i_aux_rst_n) begin
        if (!i_aux_rst_n) begin
            state     <= ST_IDLE;
            dcnt      <= '0;
            link_drop <= 1'b0;
        end else begin
            state     <= state_next;
            link_drop <= (state == ST_READY) && (state_next != ST_READY);
            if (state_next != state) begin
                dcnt <= '0;
            end else if (((state == ST_DET_DBNC) || (state == ST_POR_DBNC)) && (dcnt != '1)) begin
                dcnt <= dcnt + 1'b1;
            end
        end
    end

`ifdef AIBNDAUX_POR_TMO_EN
    // Returning from POR_DBNC keeps the count so POR glitches cannot extend the timeout.
    always_ff @(posedge i_aux_clk or negedge i_aux_rst_n) begin
        if (!i_aux_rst_n) begin
            tcnt <= '0;
        end else if ((state_next == ST_POR_WAIT) && (state != ST_POR_WAIT) &&
                     (state != ST_POR_DBNC)) begin
            tcnt <= '0;
        end else if ((state == ST_POR_WAIT) && (tcnt != '1)) begin
            tcnt <= tcnt + 1'b1;
        end
    end

    assign o_timeout = (state == ST_FAULT);
`else
    logic unused_tmo;
    assign unused_tmo = ^{i_retry, TMO_CNT};
    assign o_timeout  = 1'b0;
`endif

    assign o_state         = state;
    assign o_link_ready    = (state == ST_READY);
    assign o_device_detect = (state == ST_POR_WAIT) || (state == ST_POR_DBNC) ||
                             (state == ST_READY);
    assign o_link_drop     = link_drop;

endmodule
